// File: rtl/gaussian_stream_ctrl.sv
// Frame sequencer for a fixed-latency Gaussian blur datapath: input handshake,
// datapath occupancy shadow, EOL/EOF tagging of outputs and post-frame flush.
module gaussian_stream_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int LATENCY = 17,
  parameter int DW      = 8,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] gauss_din,
  output logic          gauss_clk_en,
  output logic          gauss_rst,
  input  logic [DW-1:0] gauss_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_eol,
  output logic          out_eof,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [LATENCY-1:0] r_vld_sr;
  logic [CW-1:0]      r_icol;
  logic [CW-1:0]      r_irow;
  logic [CW-1:0]      r_ocol;
  logic [CW-1:0]      r_orow;

  logic w_stream;
  logic w_flush;
  logic w_tail;
  logic w_room;
  logic w_adv;
  logic w_push;
  logic w_xfer;
  logic w_last_in;
  logic w_ocol_last;

  assign w_stream    = (r_state == S_STREAM);
  assign w_flush     = (r_state == S_FLUSH);
  assign w_tail      = r_vld_sr[LATENCY-1];
  // The output slot is free unless a real pixel sits at the tail unaccepted.
  assign w_room      = !w_tail || out_ready;
  assign w_adv       = w_room && (w_flush || (w_stream && (in_valid || w_tail)));
  assign w_push      = in_valid && in_ready;
  assign w_xfer      = out_valid && out_ready;
  assign w_last_in   = (r_icol == LAST_COL) && (r_irow == LAST_ROW);
  assign w_ocol_last = (r_ocol == LAST_COL);

  assign gauss_clk_en = w_adv;
  assign gauss_din    = w_push ? in_data : '0;
  assign out_valid    = w_tail;
  assign out_data     = gauss_dout;
  assign out_eol      = w_tail && w_ocol_last;
  assign out_eof      = out_eol && (r_orow == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    gauss_rst    = 1'b0;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        gauss_rst = 1'b1;
        if (start) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        // Independent of in_valid so upstream may wait on ready.
        in_ready = w_room;
        if (in_valid && w_room && w_last_in) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_vld_sr == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shadow of which datapath stages hold real pixels; bubbles shift in as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_sr <= '0;
    end else if (r_state == S_IDLE) begin
      r_vld_sr <= '0;
    end else if (w_adv) begin
      r_vld_sr <= {r_vld_sr[LATENCY-2:0], w_push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icol <= '0;
      r_irow <= '0;
    end else if (r_state == S_IDLE) begin
      r_icol <= '0;
      r_irow <= '0;
    end else if (w_push) begin
      if (r_icol == LAST_COL) begin
        r_icol <= '0;
        r_irow <= (r_irow == LAST_ROW) ? '0 : r_irow + CW'(1);
      end else begin
        r_icol <= r_icol + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ocol <= '0;
      r_orow <= '0;
    end else if (r_state == S_IDLE) begin
      r_ocol <= '0;
      r_orow <= '0;
    end else if (w_xfer) begin
      if (w_ocol_last) begin
        r_ocol <= '0;
        r_orow <= (r_orow == LAST_ROW) ? '0 : r_orow + CW'(1);
      end else begin
        r_ocol <= r_ocol + CW'(1);
      end
    end
  end

endmodule
